// File: rtl/gpio_ctlr.sv
// PerInt initiator for one gpio slave: configures direction and debounce out of
// reset, then services interrupts with an ack-then-read and forwards output writes.
module gpio_ctlr #(
  parameter int ARCHBITSZ = 32,
  parameter int IOCOUNT = 8,
  parameter logic [ARCHBITSZ-2:0] DIRMASK = '0,
  parameter logic [ARCHBITSZ-2:0] DBNCCYC = (ARCHBITSZ-1)'(16),
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic                   pi1_rdy_i,
  input  logic                   intrqst_i,
  output logic                   intrdy_o,
  input  logic [IOCOUNT-1:0]     out_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  output logic [IOCOUNT-1:0]     in_o,
  output logic                   in_valid_o,
  output logic [ARCHBITSZ-1:0]   iocount_o,
  output logic [ARCHBITSZ-1:0]   clkfreq_o,
  output logic                   cfgdone_o
);

  localparam logic [1:0] OP_NOOP = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_RW   = 2'b11;

  typedef enum logic [3:0] {
    ST_RST, ST_CFGIO, ST_CFGIOW, ST_CFGDB, ST_CFGDBW,
    ST_IDLE, ST_ACK, ST_RD, ST_RDW, ST_WR
  } state_t;

  state_t                 state_q;
  logic                   out_ready_q;
  logic                   in_valid_q;
  logic                   cfgdone_q;
  logic [IOCOUNT-1:0]     in_q;
  logic [ARCHBITSZ-1:0]   iocount_q;
  logic [ARCHBITSZ-1:0]   clkfreq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RST;
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      cfgdone_q   <= 1'b0;
      in_q        <= '0;
      iocount_q   <= '0;
      clkfreq_q   <= '0;
    end else begin
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      case (state_q)
        ST_RST:    state_q <= ST_CFGIO;
        ST_CFGIO:  if (pi1_rdy_i) state_q <= ST_CFGIOW;
        ST_CFGIOW: if (pi1_rdy_i) begin
          iocount_q <= pi1_data_i;
          state_q   <= ST_CFGDB;
        end
        ST_CFGDB:  if (pi1_rdy_i) state_q <= ST_CFGDBW;
        ST_CFGDBW: if (pi1_rdy_i) begin
          clkfreq_q <= pi1_data_i;
          cfgdone_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        // Interrupts win over writes so input changes are never starved.
        ST_IDLE: begin
          if (intrqst_i)        state_q <= ST_ACK;
          else if (out_valid_i) state_q <= ST_WR;
        end
        ST_ACK:    state_q <= ST_RD;
        ST_RD:     if (pi1_rdy_i) state_q <= ST_RDW;
        ST_RDW:    if (pi1_rdy_i) begin
          in_q       <= pi1_data_i[IOCOUNT-1:0];
          in_valid_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        ST_WR:     if (pi1_rdy_i) begin
          out_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default:   state_q <= ST_RST;
      endcase
    end
  end

  always_comb begin
    pi1_op_o   = OP_NOOP;
    pi1_data_o = '0;
    intrdy_o   = 1'b1;
    case (state_q)
      ST_CFGIO: begin
        pi1_op_o   = OP_RW;
        pi1_data_o = {1'b0, DIRMASK};
      end
      ST_CFGDB: begin
        pi1_op_o   = OP_RW;
        pi1_data_o = {1'b1, DBNCCYC};
      end
      ST_ACK:   intrdy_o = 1'b0;
      ST_RD:    pi1_op_o = OP_RD;
      ST_WR: begin
        pi1_op_o   = OP_WR;
        pi1_data_o = {{(ARCHBITSZ-IOCOUNT){1'b0}}, out_i};
      end
      default: ;
    endcase
  end

  assign pi1_addr_o  = '0;
  assign pi1_sel_o   = '1;
  assign out_ready_o = out_ready_q;
  assign in_valid_o  = in_valid_q;
  assign cfgdone_o   = cfgdone_q;
  assign in_o        = in_q;
  assign iocount_o   = iocount_q;
  assign clkfreq_o   = clkfreq_q;

endmodule

// File: tb/tb_gpio_ctlr.sv
// Directed bench for gpio_ctlr with a small PerInt slave model and a scoreboard
// of expected pi1 transactions and input snapshots.
module tb_gpio_ctlr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pi1_op;
  logic [29:0] pi1_addr;
  logic [31:0] pi1_wdata;
  logic [31:0] pi1_rdata;
  logic [3:0]  pi1_sel;
  logic        pi1_rdy;
  logic        intrqst;
  logic        intrdy;
  logic [7:0]  out_val;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  in_val;
  logic        in_valid;
  logic [31:0] iocount;
  logic [31:0] clkfreq;
  logic        cfgdone;

  logic [7:0]  slave_in;
  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  int in_cnt = 0;
  int rdy_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
  } txn_t;
  txn_t       exp_q[$];
  logic [7:0] exp_in_q[$];

  gpio_ctlr dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pi1_op_o(pi1_op), .pi1_addr_o(pi1_addr), .pi1_data_o(pi1_wdata),
    .pi1_data_i(pi1_rdata), .pi1_sel_o(pi1_sel), .pi1_rdy_i(pi1_rdy),
    .intrqst_i(intrqst), .intrdy_o(intrdy),
    .out_i(out_val), .out_valid_i(out_valid), .out_ready_o(out_ready),
    .in_o(in_val), .in_valid_o(in_valid),
    .iocount_o(iocount), .clkfreq_o(clkfreq), .cfgdone_o(cfgdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic [1:0] op, input logic [31:0] data);
    txn_t t;
    t.op = op;
    t.data = data;
    exp_q.push_back(t);
  endtask

  // Slave: answers an accepted op with read data on the following cycle.
  initial begin
    pi1_rdata = '0;
    forever begin
      @(posedge clk);
      if (rst_n && pi1_rdy && pi1_op != 2'b00) begin
        if (pi1_op == 2'b11)      pi1_rdata <= pi1_wdata[31] ? 32'd100000000 : 32'd8;
        else if (pi1_op == 2'b10) pi1_rdata <= {24'd0, slave_in};
        else                      pi1_rdata <= '0;
      end
    end
  end

  // Monitor on the falling edge: an op seen with rdy=1 is accepted on the next rise.
  initial begin
    txn_t e;
    logic [7:0] ei;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (intrdy === 1'b0) ack_cnt++;
        if (out_ready === 1'b1) rdy_cnt++;
        if (in_valid === 1'b1) begin
          in_cnt++;
          if (exp_in_q.size() == 0) chk("in_unexpected", 64'(exp_in_q.size()), 64'd1);
          else begin
            ei = exp_in_q.pop_front();
            chk("in_o", 64'(in_val), 64'(ei));
          end
        end
        if (pi1_rdy === 1'b1 && pi1_op !== 2'b00) begin
          if (exp_q.size() == 0) chk("pi1_unexpected", 64'(exp_q.size()), 64'd1);
          else begin
            e = exp_q.pop_front();
            chk("pi1_txn", {30'd0, pi1_op, pi1_wdata}, {30'd0, e.op, e.data});
          end
        end
      end
    end
  end

  initial begin
    int a0, i0, r0;
    rst_n = 1'b0; pi1_rdy = 1'b1; intrqst = 1'b0;
    out_val = '0; out_valid = 1'b0; slave_in = '0;
    #12;
    chk("rst_op", 64'(pi1_op), 64'd0);
    chk("rst_data", 64'(pi1_wdata), 64'd0);
    chk("rst_intrdy", 64'(intrdy), 64'd1);
    chk("rst_cfgdone", 64'(cfgdone), 64'd0);
    chk("rst_iocount", 64'(iocount), 64'd0);
    chk("rst_outs", {in_val, in_valid, out_ready, clkfreq}, 64'd0);
    chk("addr_sel", {pi1_addr, pi1_sel}, {30'd0, 4'hF});

    // Configuration sequence
    push_txn(2'b11, 32'h0000_0000);
    push_txn(2'b11, 32'h8000_0010);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("cfgio_op", {pi1_op, pi1_wdata}, {2'b11, 32'h0});
    tick(); tick(); tick();
    chk("cfgdone_e4", 64'(cfgdone), 64'd0);
    tick();
    chk("cfgdone_e5", 64'(cfgdone), 64'd1);
    chk("iocount", 64'(iocount), 64'd8);
    chk("clkfreq", 64'(clkfreq), 64'd100000000);
    chk("cfg_txns_done", 64'(exp_q.size()), 64'd0);

    // Interrupt service
    a0 = ack_cnt; i0 = in_cnt;
    @(negedge clk);
    slave_in = 8'hA5; intrqst = 1'b1;
    push_txn(2'b10, 32'h0); exp_in_q.push_back(8'hA5);
    tick();
    chk("ack_low", 64'(intrdy), 64'd0);
    intrqst = 1'b0;
    tick();
    chk("ack_one_cycle", {intrdy, pi1_op}, {1'b1, 2'b10});
    tick();
    chk("rdw_noop", 64'(pi1_op), 64'd0);
    tick();
    chk("irq_in_valid", {in_valid, in_val}, {1'b1, 8'hA5});
    tick(); tick();
    chk("irq_ack_count", 64'(ack_cnt - a0), 64'd1);
    chk("irq_in_count", 64'(in_cnt - i0), 64'd1);

    // Output write
    r0 = rdy_cnt;
    @(negedge clk);
    out_val = 8'h3C; out_valid = 1'b1;
    push_txn(2'b01, 32'h3C);
    tick();
    chk("wr_op", {pi1_op, pi1_wdata}, {2'b01, 32'h3C});
    tick();
    chk("wr_ready", 64'(out_ready), 64'd1);
    out_valid = 1'b0;
    tick(); tick(); tick();
    chk("wr_single", {64'(rdy_cnt - r0)}, 64'd1);
    chk("wr_idle_op", 64'(pi1_op), 64'd0);

    // Interrupt and write in the same cycle
    r0 = rdy_cnt;
    @(negedge clk);
    slave_in = 8'h5A; intrqst = 1'b1; out_val = 8'hC3; out_valid = 1'b1;
    push_txn(2'b10, 32'h0); push_txn(2'b01, 32'hC3); exp_in_q.push_back(8'h5A);
    tick();
    chk("both_ack_first", 64'(intrdy), 64'd0);
    intrqst = 1'b0;
    tick(); tick(); tick();
    chk("both_in_valid", {in_valid, in_val, out_ready}, {1'b1, 8'h5A, 1'b0});
    tick();
    chk("both_wr_op", {out_ready, pi1_op}, {1'b0, 2'b01});
    tick();
    chk("both_ready", 64'(out_ready), 64'd1);
    out_valid = 1'b0;
    tick(); tick();
    chk("both_ready_count", 64'(rdy_cnt - r0), 64'd1);

    // Read stalled by pi1_rdy low for three cycles
    @(negedge clk);
    slave_in = 8'h77; intrqst = 1'b1;
    push_txn(2'b10, 32'h0); exp_in_q.push_back(8'h77);
    tick();
    intrqst = 1'b0;
    tick();
    pi1_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_rd_held", {pi1_op, pi1_wdata}, {2'b10, 32'h0});
      tick();
    end
    chk("stall_rd_last", 64'(pi1_op), 64'd2);
    pi1_rdy = 1'b1;
    tick();
    chk("stall_no_capture", {in_valid, in_val}, {1'b0, 8'h5A});
    tick();
    chk("stall_capture", {in_valid, in_val}, {1'b1, 8'h77});
    tick(); tick();

    // Reset during a stalled write
    @(negedge clk);
    pi1_rdy = 1'b0; out_val = 8'h11; out_valid = 1'b1;
    tick();
    chk("rstwr_op", 64'(pi1_op), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstwr_abort", {pi1_op, intrdy, cfgdone, in_val, iocount}, {2'b00, 1'b1, 1'b0, 8'h0, 32'h0});
    out_valid = 1'b0; pi1_rdy = 1'b1;
    push_txn(2'b11, 32'h0000_0000);
    push_txn(2'b11, 32'h8000_0010);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("re_cfgdone_e4", 64'(cfgdone), 64'd0);
    tick();
    chk("re_cfgdone_e5", {cfgdone, iocount, clkfreq}, {1'b1, 32'd8, 32'd100000000});
    tick(); tick();
    chk("scoreboard_txn_empty", 64'(exp_q.size()), 64'd0);
    chk("scoreboard_in_empty", 64'(exp_in_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_ctlr.md
# gpio_ctlr

PerInt initiator and interrupt servicer for one gpio peripheral. Out of reset it configures the gpio slave: direction first, then debounce. It then acknowledges each gpio interrupt and reads back a fresh input snapshot. It also forwards output-write requests from local logic as PIWROP transactions. It sits between the gpio slave's pi1/intrqst/intrdy pins and fabric logic that wants GPIO state as a valid-strobed bus.

## Interface
- ARCHBITSZ, 32: data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
- IOCOUNT, 8: IO count, 1..ARCHBITSZ-1.
- DIRMASK, 0: CMDCONFIGUREIO argument; bit=1 marks that IO as an output.
- DBNCCYC, 16: CMDSETDEBOUNCE argument, in clock cycles.
- clk_i  in  1  clock; everything on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- pi1_op_o  out  2  PerInt op: NOOP=00, WR=01, RD=10, RW=11.
- pi1_addr_o  out  ADDRBITSZ  always 0.
- pi1_data_o  out  ARCHBITSZ  write data / command word.
- pi1_data_i  in  ARCHBITSZ  slave read data.
- pi1_sel_o  out  ARCHBITSZ/8  always all ones.
- pi1_rdy_i  in  1  slave ready.
- intrqst_i  in  1  slave interrupt request.
- intrdy_o  out  1  interrupt acknowledge; idle high; a falling edge acks.
- out_i  in  IOCOUNT  requested output values.
- out_valid_i  in  1  output write request.
- out_ready_o  out  1  one-cycle pulse when the write is accepted by the slave.
- in_o  out  IOCOUNT  last input snapshot.
- in_valid_o  out  1  one-cycle pulse when in_o updates.
- iocount_o  out  ARCHBITSZ  captured CMDCONFIGUREIO return.
- clkfreq_o  out  ARCHBITSZ  captured CMDSETDEBOUNCE return.
- cfgdone_o  out  1  high once both config commands have completed.

## Operation
- States: RST, CFGIO, CFGIOW, CFGDB, CFGDBW, IDLE, ACK, RD, RDW, WR.
- pi1_op_o, pi1_data_o and intrdy_o decode from the state register. Every other output is registered.
- CFGIO drives op=RW with data {1'b0, DIRMASK zero-extended to ARCHBITSZ-1}.
- CFGDB drives op=RW with data {1'b1, DBNCCYC}.
- RD drives op=RD with data 0.
- WR drives op=WR with data = out_i zero-extended.
- All other states drive op=NOOP and data 0.
- An op is accepted on the edge where pi1_rdy_i=1. The issuing state holds until acceptance.
- Transitions on acceptance: CFGIO→CFGIOW, CFGDB→CFGDBW, RD→RDW, WR→IDLE.
- The slave returns read data one cycle after acceptance. In each *W state, capture pi1_data_i on the first edge with pi1_rdy_i=1:
  - CFGIOW → iocount_o, go to CFGDB.
  - CFGDBW → clkfreq_o, set cfgdone_o, go to IDLE.
  - RDW → in_o = pi1_data_i[IOCOUNT-1:0], pulse in_valid_o, go to IDLE.
- IDLE priority:
  - intrqst_i=1 → ACK.
  - else out_valid_i=1 → WR.
  - else stay.
- ACK lasts exactly one cycle with intrdy_o=0, then goes to RD. Acknowledging before reading guarantees that changes occurring after the read re-raise intrqst_i.
- intrqst_i is sampled only in IDLE.
- out_ready_o pulses on the WR acceptance edge. The requester holds out_valid_i and out_i stable until out_ready_o.
- Reset values:
  - state RST; pi1_op_o=00; pi1_data_o=0; intrdy_o=1.
  - out_ready_o=0, in_valid_o=0, cfgdone_o=0.
  - in_o=0, iocount_o=0, clkfreq_o=0.
- Assertion of rst_ni mid-transaction aborts immediately. All outputs return to reset values asynchronously.

## Timing
- First edge after rst_ni rises: RST→CFGIO.
- With pi1_rdy_i held at 1: CFGIO 1 cycle, CFGIOW 1, CFGDB 1, CFGDBW 1. cfgdone_o rises on the 5th edge after release.
- Interrupt latency with rdy=1:
  - IDLE sees intrqst_i at edge n.
  - ACK during cycle n..n+1.
  - RD at n+1..n+2.
  - in_valid_o pulses after edge n+3.
- Write latency with rdy=1: out_valid_i seen at edge n, WR during n..n+1, out_ready_o pulses after edge n+1.
- A stalled pi1_rdy_i extends the current state one cycle per low cycle. Op and data stay stable throughout.

## Test plan
- Reset then rdy=1; slave returns 8 then 100000000:
  - pi1 sequence is RW 0x00000000 then RW 0x80000010.
  - iocount_o=8, clkfreq_o=100000000.
  - cfgdone_o rises on edge 5.
- In IDLE, intrqst_i=1 and slave data 0xA5:
  - intrdy_o low exactly 1 cycle, then one RD.
  - in_o=0xA5 with a single in_valid_o pulse.
- out_valid_i=1, out_i=0x3C:
  - one WR with data 0x3C.
  - out_ready_o pulses once; no second WR while out_valid_i is dropped.
- intrqst_i and out_valid_i rise in the same cycle:
  - ACK/RD complete first, then WR.
  - out_ready_o arrives 2 cycles after in_valid_o.
- pi1_rdy_i low for 3 cycles during RD: op=RD held for 4 cycles; in_o captured only after rdy returns.
- rst_ni asserted during WR: pi1_op_o=00 and intrdy_o=1 immediately; after release the full config sequence repeats.
